// File: rtl/fir_lp15_pkg.sv
// Shared constants, state encoding and coefficients for the 15-tap symmetric low-pass FIR.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fir_lp15_pkg;

    localparam int TAPS     = 15;
    localparam int DW       = 8;
    localparam int ACC_W    = 29;
    localparam int OUT_LSB  = 21;
    localparam int CW       = 17;
    localparam int NUM_COEF = (TAPS + 1) / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Folded coefficient C[k]; C[7] is the centre tap.
    function automatic logic signed [CW-1:0] coef(input logic [2:0] k);
        case (k)
            3'd0:    coef = 17'sd5241;
            3'd1:    coef = 17'sd8226;
            3'd2:    coef = 17'sd16590;
            3'd3:    coef = 17'sd28678;
            3'd4:    coef = 17'sd42095;
            3'd5:    coef = 17'sd54183;
            3'd6:    coef = 17'sd62549;
            default: coef = 17'sd65535;
        endcase
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first active request at or above the pointer, with wrap.
// Latency: combinational.
// Backpressure: none; the caller decides whether the grant is consumed.
module rr_arbiter #(
    parameter  int NUM_CH = 2,
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_o,
    output logic [IW-1:0]     idx_o
);

    logic found;
    int   cand;

    // Scan channels starting at the pointer, stop at the first requester.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(ptr_i) + i) % NUM_CH;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/fir_share_seq.sv
// One serial MAC shared round-robin across NUM_CH streams, 15-tap symmetric low-pass each.
// Latency: input handshake at edge T, result valid after edge T+9 (8 folded MACs + product drain).
// Backpressure: result held in DONE until out_ready; no input is accepted outside IDLE.
module fir_share_seq
    import fir_lp15_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int IW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    in_valid,
    input  logic [NUM_CH*DW-1:0] in_data,
    output logic [NUM_CH-1:0]    in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IW-1:0]        out_ch,
    output logic [DW-1:0]        out_data,
    output logic                 busy
);

    localparam int PREW = DW + 1;
    localparam int PW   = PREW + CW;

    state_t                    state_q, state_d;
    logic [3:0]                k_q, k_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d, acc_sum;
    logic signed [PW-1:0]      prod_q, prod_d, prod;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [IW-1:0]             ch_q, ch_d;
    logic [IW-1:0]             out_ch_q, out_ch_d;
    logic                      out_valid_q, out_valid_d;
    logic [DW-1:0]             out_data_q, out_data_d;
    logic signed [DW-1:0]      dly_q [NUM_CH][TAPS];
    logic signed [DW-1:0]      dly_d [NUM_CH][TAPS];

    logic [NUM_CH-1:0]         gnt;
    logic [IW-1:0]             gnt_idx;
    logic [2:0]                tap_lo;
    logic [3:0]                tap_hi;
    logic signed [DW-1:0]      op_lo, op_hi;
    logic signed [PREW-1:0]    pre_add;
    logic signed [CW-1:0]      c_k;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req_i (in_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    // Folded tap pair for step k; the product is registered so the multiplier
    // does not sit in series with the accumulator adder, hence one drain step.
    always_comb begin
        tap_lo  = k_q[2:0];
        tap_hi  = 4'(TAPS - 1) - {1'b0, tap_lo};
        op_lo   = dly_q[ch_q][tap_lo];
        op_hi   = dly_q[ch_q][tap_hi];
        pre_add = (tap_lo == 3'd7) ? PREW'(op_lo) : PREW'(op_lo) + PREW'(op_hi);
        c_k     = coef(tap_lo);
        prod    = PW'(pre_add) * PW'(c_k);
        acc_sum = acc_q + ACC_W'(prod_q);
    end

    // Next-state and handshake decode for IDLE -> MAC -> DONE.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        dly_d       = dly_q;
        in_ready    = '0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n ? gnt : '0;
                if (|gnt) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        dly_d[gnt_idx][i] = dly_q[gnt_idx][i-1];
                    end
                    dly_d[gnt_idx][0] = in_data[gnt_idx*DW +: DW];
                    ptr_d   = (gnt_idx == IW'(NUM_CH - 1)) ? '0 : gnt_idx + IW'(1);
                    ch_d    = gnt_idx;
                    acc_d   = '0;
                    prod_d  = '0;
                    k_d     = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                prod_d = prod;
                acc_d  = acc_sum;
                k_d    = k_q + 4'd1;
                if (k_q == 4'(NUM_COEF)) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_sum[OUT_LSB+DW-1:OUT_LSB];
                    out_ch_d    = ch_q;
                    k_d         = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            ptr_q       <= '0;
            ch_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            dly_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            dly_q       <= dly_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fir_share_seq.sv
// Directed and randomized bench for the shared-MAC FIR against a direct-form reference.
// Latency: checks 9 cycles from input handshake to out_valid.
// Backpressure: exercises a 20-cycle output stall with a second producer pending.
module tb_fir_share_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  in_valid;
    logic [15:0] in_data;
    logic [1:0]  in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [7:0]  out_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    int hist [2][15];
    int h_full [15] = '{5241, 8226, 16590, 28678, 42095, 54183, 62549, 65535,
                        62549, 54183, 42095, 28678, 16590, 8226, 5241};
    int imp_exp [15] = '{0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 2, 1, 1, 0, 0};

    always #5 clk = ~clk;

    fir_share_seq #(.NUM_CH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .busy      (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 15; i++) hist[c][i] = 0;
    endtask

    task automatic push_model(input int ch, input int smp);
        for (int i = 14; i > 0; i--) hist[ch][i] = hist[ch][i-1];
        hist[ch][0] = smp;
    endtask

    // Direct-form convolution, 29-bit wrap, then floor to the 8-bit output window.
    function automatic int golden(input int ch);
        longint s;
        logic signed [7:0] b;
        s = 0;
        for (int i = 0; i < 15; i++) s += longint'(hist[ch][i]) * longint'(h_full[i]);
        s = (s <<< 35) >>> 35;
        s = s >>> 21;
        b = s[7:0];
        return int'(b);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    // One sample in, one result out; caller controls out_ready.
    task automatic xfer(input int ch, input int smp, output int res, output int rch);
        int n;
        in_data[ch*8 +: 8] = 8'(smp);
        in_valid[ch] = 1'b1;
        #1;
        n = 0;
        while (in_ready[ch] !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("grant_timeout", n, 0);
            in_valid[ch] = 1'b0;
            res = 0;
            rch = 0;
            return;
        end
        @(negedge clk);
        in_valid[ch] = 1'b0;
        push_model(ch, smp);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 9);
        res = int'($signed(out_data));
        rch = int'(out_ch);
        @(negedge clk);
    endtask

    task automatic run_impulse(input string tag);
        int r, c;
        for (int i = 0; i < 15; i++) begin
            xfer(0, (i == 0) ? 127 : 0, r, c);
            chk($sformatf("%s_%0d", tag, i), r, imp_exp[i]);
            chk($sformatf("%s_ch%0d", tag, i), c, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c, n, g, exp_gnt, ocount, ug, e0;
        int qd[$];
        int qc[$];
        logic signed [7:0] vals [2];
        bit upd;

        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        clear_model();
        repeat (3) @(negedge clk);

        // Reset state
        in_valid = 2'b11;
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        in_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Impulse on ch0
        run_impulse("imp");

        // DC up then down on ch1, zeros on ch0 in between
        for (int i = 0; i < 15; i++) begin
            xfer(1, 127, r, c);
            chk("dc_up_model", r, golden(1));
            chk("dc_up_ch", c, 1);
            if (i == 14) chk("dc_up_final", r, 30);
            xfer(0, 0, r, c);
            chk("dc_ch0_zero", r, 0);
        end
        for (int i = 0; i < 15; i++) begin
            xfer(1, -128, r, c);
            chk("dc_dn_model", r, golden(1));
            if (i == 14) chk("dc_dn_final", r, -31);
            xfer(0, 0, r, c);
            chk("dc_ch0_zero", r, 0);
        end

        // Back-pressure with ch1 pending
        for (int i = 0; i < 3; i++) begin
            xfer(0, 100, r, c);
            chk("bp_pre", r, golden(0));
        end
        out_ready = 1'b0;
        xfer(0, 100, r, c);
        e0 = golden(0);
        chk("bp_first", r, e0);
        chk("bp_first_val", r, 2);
        in_data[15:8] = 8'(-77);
        in_valid[1]   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_data", int'($signed(out_data)), e0);
            chk("bp_hold_ch", int'(out_ch), 0);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_busy", int'(busy), 1);
        end
        out_ready = 1'b1;
        xfer(1, -77, r, c);
        chk("bp_pending_data", r, golden(1));
        chk("bp_pending_ch", c, 1);

        // Contention: both channels requesting from reset
        in_valid = 2'b11;
        vals[0] = 8'sd10;
        vals[1] = -8'sd20;
        in_data = {vals[1], vals[0]};
        do_reset();
        exp_gnt = 0;
        ocount  = 0;
        upd     = 1'b0;
        ug      = 0;
        for (int cyc = 0; cyc < 300 && ocount < 8; cyc++) begin
            #1;
            chk("cont_onehot", int'(in_ready == 2'b11), 0);
            if (in_ready != 2'b00) begin
                g = in_ready[1] ? 1 : 0;
                chk("cont_grant", g, exp_gnt);
                exp_gnt ^= 1;
                push_model(g, int'(vals[g]));
                qd.push_back(golden(g));
                qc.push_back(g);
                upd = 1'b1;
                ug  = g;
            end
            if (out_valid) begin
                if (qd.size() > 0) begin
                    chk("cont_data", int'($signed(out_data)), qd.pop_front());
                    chk("cont_ch", int'(out_ch), qc.pop_front());
                end else begin
                    chk("cont_unexpected_out", 1, 0);
                end
                ocount++;
            end
            @(negedge clk);
            if (upd) begin
                vals[ug] = vals[ug] + ((ug == 0) ? 8'sd29 : -8'sd13);
                in_data[ug*8 +: 8] = vals[ug];
                upd = 1'b0;
            end
        end
        chk("cont_outputs", ocount, 8);
        in_valid = '0;
        repeat (15) @(negedge clk);

        // Reset in the middle of MAC
        in_data[7:0] = 8'd100;
        in_valid[0]  = 1'b1;
        #1;
        n = 0;
        while (in_ready[0] !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("mid_grant_wait", int'(n < 100), 1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_out_valid", int'(out_valid), 0);
        chk("mid_busy_after", int'(busy), 0);
        rst_n = 1'b1;
        clear_model();
        @(negedge clk);
        run_impulse("imp_rst");

        // Random samples on both channels against the reference
        for (int i = 0; i < 300; i++) begin
            g = $urandom_range(0, 1);
            n = $urandom_range(0, 255) - 128;
            xfer(g, n, r, c);
            chk("rand_data", r, golden(g));
            chk("rand_ch", c, g);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
